// File: rtl/mas_fetch_seq.sv
// MAS program loader and instruction-fetch sequencer.
// Loads words into memory port A, then fetches and issues to decode.
module mas_fetch_seq #(
  parameter int            DW        = 16,
  parameter int            AW        = 16,
  parameter logic [AW-1:0] BASE_ADDR = 16'h8000,
  parameter int            IB        = 2,
  parameter int            DEPTH     = 2048
) (
  input  logic                         clk,
  input  logic                         rstz,
  input  logic                         pg,
  input  logic                         pg_valid,
  input  logic [DW-1:0]                pg_data,
  output logic                         pg_ready,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [AW-1:0]                mem_addr,
  output logic [DW-1:0]                mem_wdata,
  input  logic                         mem_ack,
  input  logic [DW-1:0]                mem_rdata,
  output logic [DW-1:0]                instr,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  input  logic                         br_taken,
  input  logic [AW-1:0]                br_offset,
  input  logic                         halt_req,
  output logic [AW-1:0]                pc,
  output logic [$clog2(DEPTH+1)-1:0]   prog_len,
  output logic                         halted,
  output logic [1:0]                   fault
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = AW + CW + $clog2(IB + 1) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] count;
  logic [AW-1:0] npc;
  logic [AW-1:0] noff;
  logic [EW-1:0] lim;
  logic          misal;
  logic          oor;
  logic [AW-1:0] waddr;

  // Next PC and its legality, evaluated against the loaded program
  always_comb begin
    npc   = br_taken ? pc + br_offset : pc + AW'(IB);
    noff  = npc - BASE_ADDR;
    misal = (noff % AW'(IB)) != '0;
    lim   = EW'(BASE_ADDR) + EW'(prog_len) * EW'(IB);
    oor   = (npc < BASE_ADDR) || (EW'(npc) >= lim);
    waddr = BASE_ADDR + AW'(count) * AW'(IB);
  end

  assign pg_ready = (state == S_LOAD) && !mem_req && pg
                    && (count < CW'(DEPTH));
  assign halted   = (state == S_HALT);

  // Sequencer state, memory port and issue registers
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state       <= S_IDLE;
      pc          <= BASE_ADDR;
      prog_len    <= '0;
      fault       <= 2'd0;
      count       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (mem_req && mem_ack)
        mem_req <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pg) begin
            state <= S_LOAD;
            count <= '0;
            fault <= 2'd0;
          end else if (prog_len != '0) begin
            state <= S_FETCH;
          end
        end
        S_LOAD: begin
          if (mem_req && mem_ack && mem_we)
            count <= count + 1'b1;
          if (pg_valid && pg_ready) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= waddr;
            mem_wdata <= pg_data;
          end
          if (count == CW'(DEPTH))
            fault <= 2'd1;
          if (!pg && !mem_req) begin
            state    <= S_IDLE;
            prog_len <= count;
            pc       <= BASE_ADDR;
          end
        end
        S_FETCH: begin
          if (pg) begin
            state <= S_LOAD;
            count <= '0;
            fault <= 2'd0;
          end else if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (pg) begin
            state       <= S_LOAD;
            count       <= '0;
            fault       <= 2'd0;
            instr_valid <= 1'b0;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            if (halt_req) begin
              state <= S_HALT;
            end else if (misal) begin
              state <= S_HALT;
              fault <= 2'd3;
            end else if (oor) begin
              state <= S_HALT;
              fault <= 2'd2;
            end else begin
              pc    <= npc;
              state <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          if (pg) begin
            state <= S_LOAD;
            count <= '0;
            fault <= 2'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mas_fetch_seq.sv
// Directed bench for mas_fetch_seq with a variable-latency memory.
// Runs with DEPTH=4 so the overflow path is reachable.
module tb_mas_fetch_seq;

  logic        clk;
  logic        rstz;
  logic        pg;
  logic        pg_valid;
  logic [15:0] pg_data;
  logic        pg_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_taken;
  logic [15:0] br_offset;
  logic        halt_req;
  logic [15:0] pc;
  logic [2:0]  prog_len;
  logic        halted;
  logic [1:0]  fault;

  int errors = 0;
  int checks = 0;
  int lat = 0;
  int wcnt = 0;

  logic [15:0] mem [8];
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] rd_addr_q[$];
  logic [15:0] iss_q[$];

  mas_fetch_seq #(
    .DW(16), .AW(16), .BASE_ADDR(16'h8000), .IB(2), .DEPTH(4)
  ) dut (
    .clk(clk), .rstz(rstz), .pg(pg), .pg_valid(pg_valid),
    .pg_data(pg_data), .pg_ready(pg_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_taken(br_taken), .br_offset(br_offset), .halt_req(halt_req),
    .pc(pc), .prog_len(prog_len), .halted(halted), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: acks after lat extra cycles, answers at the falling edge
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req && rstz) begin
      if (wcnt >= lat) begin
        mem_ack = 1'b1;
        wcnt = 0;
        if (mem_we) begin
          mem[mem_addr[3:1]] = mem_wdata;
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_wdata);
        end else begin
          mem_rdata = mem[mem_addr[3:1]];
          rd_addr_q.push_back(mem_addr);
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Issue handshake log, sampled just before the rising edge
  always begin
    @(negedge clk);
    #4;
    if (rstz && instr_valid && instr_ready && !pg)
      iss_q.push_back(instr);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load_words(input int n, input int l,
                            input logic [15:0] w0);
    lat = l;
    wr_addr_q.delete();
    wr_data_q.delete();
    pg = 1'b1;
    pg_valid = 1'b0;
    step();
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < 20 && !pg_ready; t++) step();
      if (!pg_ready) break;
      pg_valid = 1'b1;
      pg_data = w0 + 16'(i);
      step();
      pg_valid = 1'b0;
      for (int t = 0; t < 20 && mem_req; t++) step();
    end
  endtask

  task automatic end_load();
    pg = 1'b0;
    step();
    rd_addr_q.delete();
    iss_q.delete();
  endtask

  task automatic test_reset();
    rstz = 1'b0;
    pg = 0; pg_valid = 0; pg_data = 0;
    instr_ready = 0; br_taken = 0; br_offset = 0; halt_req = 0;
    mem_ack = 0; mem_rdata = 0;
    step(); step();
    checks++;
    if (pc !== 16'h8000) begin
      errors++; $display("FAIL reset_pc got %h want 8000", pc);
    end
    checks++;
    if ({mem_req, mem_we, instr_valid, halted, pg_ready} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 00000",
        {mem_req, mem_we, instr_valid, halted, pg_ready});
    end
    checks++;
    if ({prog_len, fault} !== 5'b0) begin
      errors++; $display("FAIL reset_len_fault got %b want 0", {prog_len, fault});
    end
    checks++;
    if ({instr, mem_addr, mem_wdata} !== 48'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", {instr, mem_addr, mem_wdata});
    end
    rstz = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_load();
    lat = 3;
    wr_addr_q.delete();
    pg = 1'b1;
    step();
    pg_valid = 1'b1; pg_data = 16'h1234;
    step();
    pg_valid = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL midload_outstanding got %b want 1", mem_req);
    end
    #1 rstz = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL midload_req got %b want 0", mem_req);
    end
    checks++;
    if (pc !== 16'h8000 || prog_len !== 3'd0) begin
      errors++; $display("FAIL midload_state got pc=%h len=%0d want 8000 0", pc, prog_len);
    end
    pg = 1'b0;
    step();
    rstz = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (wr_addr_q.size() != 0) begin
      errors++; $display("FAIL midload_writes got %0d want 0", wr_addr_q.size());
    end
  endtask

  task automatic test_zero_load();
    pg = 1'b1;
    step(); step();
    pg = 1'b0;
    rd_addr_q.delete();
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (prog_len !== 3'd0 || halted !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL zero_load got len=%0d halt=%b req=%b want 0 0 0",
        prog_len, halted, mem_req);
    end
    checks++;
    if (rd_addr_q.size() != 0) begin
      errors++; $display("FAIL zero_load_reads got %0d want 0", rd_addr_q.size());
    end
  endtask

  task automatic test_load();
    logic [15:0] ea;
    instr_ready = 1'b0;
    load_words(4, 3, 16'hA000);
    end_load();
    for (int t = 0; t < 30 && !instr_valid; t++) step();
    for (int i = 0; i < 4; i++) begin
      ea = 16'h8000 + 16'(2 * i);
      checks++;
      if (wr_addr_q[i] !== ea) begin
        errors++; $display("FAIL load_waddr%0d got %h want %h", i, wr_addr_q[i], ea);
      end
    end
    checks++;
    if (wr_data_q[3] !== 16'hA003) begin
      errors++; $display("FAIL load_wdata3 got %h want a003", wr_data_q[3]);
    end
    checks++;
    if (prog_len !== 3'd4) begin
      errors++; $display("FAIL load_len got %0d want 4", prog_len);
    end
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'hA000 || pc !== 16'h8000) begin
      errors++; $display("FAIL load_first got v=%b i=%h pc=%h want 1 a000 8000",
        instr_valid, instr, pc);
    end
    checks++;
    if (rd_addr_q[0] !== 16'h8000) begin
      errors++; $display("FAIL load_raddr got %h want 8000", rd_addr_q[0]);
    end
  endtask

  task automatic test_seq_run();
    load_words(4, 0, 16'hB000);
    checks++;
    if (wr_addr_q[3] !== 16'h8006 || wr_addr_q.size() != 4) begin
      errors++; $display("FAIL seq_waddr got %h n=%0d want 8006 4",
        wr_addr_q[3], wr_addr_q.size());
    end
    end_load();
    instr_ready = 1'b1;
    for (int t = 0; t < 60 && !halted; t++) step();
    checks++;
    if (halted !== 1'b1 || fault !== 2'd2 || pc !== 16'h8006) begin
      errors++; $display("FAIL seq_end got h=%b f=%0d pc=%h want 1 2 8006",
        halted, fault, pc);
    end
    checks++;
    if (rd_addr_q.size() != 4 || rd_addr_q[3] !== 16'h8006
        || rd_addr_q[1] !== 16'h8002) begin
      errors++; $display("FAIL seq_reads got n=%0d r1=%h r3=%h want 4 8002 8006",
        rd_addr_q.size(), rd_addr_q[1], rd_addr_q[3]);
    end
    checks++;
    if (iss_q.size() != 4 || iss_q[2] !== 16'hB002) begin
      errors++; $display("FAIL seq_issue got n=%0d i2=%h want 4 b002",
        iss_q.size(), iss_q[2]);
    end
  endtask

  task automatic test_branch();
    int nbr = 0;
    load_words(4, 0, 16'hC000);
    end_load();
    instr_ready = 1'b1;
    for (int t = 0; t < 80 && !halted; t++) begin
      step();
      br_taken = 1'b0;
      if (instr_valid && pc == 16'h8002) begin
        nbr++;
        br_taken = 1'b1;
        br_offset = (nbr == 1) ? 16'hFFFE : 16'h0003;
      end
    end
    br_taken = 1'b0;
    checks++;
    if (rd_addr_q.size() != 4 || rd_addr_q[2] !== 16'h8000) begin
      errors++; $display("FAIL br_back got n=%0d r2=%h want 4 8000",
        rd_addr_q.size(), rd_addr_q[2]);
    end
    checks++;
    if (halted !== 1'b1 || fault !== 2'd3 || pc !== 16'h8002) begin
      errors++; $display("FAIL br_misal got h=%b f=%0d pc=%h want 1 3 8002",
        halted, fault, pc);
    end
  endtask

  task automatic test_pg_preempt();
    instr_ready = 1'b0;
    load_words(4, 0, 16'hE000);
    end_load();
    for (int t = 0; t < 30 && !instr_valid; t++) step();
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'hE000) begin
      errors++; $display("FAIL pre_ready got v=%b i=%h want 1 e000", instr_valid, instr);
    end
    pg = 1'b1; instr_ready = 1'b1;
    br_taken = 1'b1; br_offset = 16'h0003;
    step();
    br_taken = 1'b0; instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || pg_ready !== 1'b1) begin
      errors++; $display("FAIL pre_load got v=%b rdy=%b want 0 1", instr_valid, pg_ready);
    end
    checks++;
    if (halted !== 1'b0 || fault !== 2'd0 || pc !== 16'h8000 || prog_len !== 3'd4) begin
      errors++; $display("FAIL pre_nobr got h=%b f=%0d pc=%h len=%0d want 0 0 8000 4",
        halted, fault, pc, prog_len);
    end
    load_words(4, 0, 16'hF000);
    end_load();
    for (int t = 0; t < 30 && !instr_valid; t++) step();
    checks++;
    if (instr !== 16'hF000 || pc !== 16'h8000) begin
      errors++; $display("FAIL pre_reload got i=%h pc=%h want f000 8000", instr, pc);
    end
  endtask

  task automatic test_drain();
    lat = 3;
    instr_ready = 1'b1;
    step();
    for (int t = 0; t < 10 && !(mem_req && !mem_we); t++) step();
    pg = 1'b1; instr_ready = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b1 || pg_ready !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL drain_hold got req=%b rdy=%b v=%b want 1 0 0",
        mem_req, pg_ready, instr_valid);
    end
    for (int t = 0; t < 10 && !pg_ready; t++) step();
    checks++;
    if (pg_ready !== 1'b1 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL drain_done got rdy=%b v=%b want 1 0", pg_ready, instr_valid);
    end
  endtask

  task automatic test_overflow();
    load_words(5, 0, 16'hD000);
    checks++;
    if (wr_addr_q.size() != 4 || pg_ready !== 1'b0 || fault !== 2'd1) begin
      errors++; $display("FAIL ovf_stop got n=%0d rdy=%b f=%0d want 4 0 1",
        wr_addr_q.size(), pg_ready, fault);
    end
    pg_valid = 1'b1; pg_data = 16'hD004;
    step(); step();
    pg_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || wr_addr_q.size() != 4) begin
      errors++; $display("FAIL ovf_extra got req=%b n=%0d want 0 4",
        mem_req, wr_addr_q.size());
    end
    end_load();
    checks++;
    if (prog_len !== 3'd4) begin
      errors++; $display("FAIL ovf_len got %0d want 4", prog_len);
    end
    instr_ready = 1'b1;
    for (int t = 0; t < 60 && !halted; t++) begin
      step();
      halt_req = instr_valid && (pc == 16'h8004);
    end
    halt_req = 1'b0;
    checks++;
    if (iss_q.size() != 3 || iss_q[0] !== 16'hD000) begin
      errors++; $display("FAIL ovf_run got n=%0d i0=%h want 3 d000",
        iss_q.size(), iss_q[0]);
    end
    checks++;
    if (halted !== 1'b1 || pc !== 16'h8004 || fault !== 2'd1) begin
      errors++; $display("FAIL ovf_halt got h=%b pc=%h f=%0d want 1 8004 1",
        halted, pc, fault);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_zero_load();
    test_load();
    test_seq_run();
    test_branch();
    test_pg_preempt();
    test_drain();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mas_fetch_seq.md
Name: mas_fetch_seq

Overview:
- Parametrised program loader and instruction-fetch sequencer for the MAS core family.
- Generalises the 16-bit core's fixed PC, programming mode and next-PC logic:
  - configurable data width, address width, base address, instruction size and program depth;
  - request/acknowledge memory port with variable latency;
  - valid/ready instruction issue toward decode;
  - bounds, alignment and overflow fault detection with halt.
- Sits between the program-load interface, the shared instruction/data memory port A and the instruction decoder.

Parameters:
- DW, 16, instruction and load-data width.
- AW, 16, byte address width; PC arithmetic wraps mod 2^AW.
- BASE_ADDR, 16'h8000, address of the first instruction.
- IB, 2, bytes per instruction (PC increment).
- DEPTH, 2048, maximum loadable instructions; counter width is clog2(DEPTH+1).

Ports:
- clk  in  1  clock, rising edge.
- rstz  in  1  asynchronous active-low reset.
- pg  in  1  programming mode request (level).
- pg_valid  in  1  load word valid.
- pg_data  in  DW  load word.
- pg_ready  out  1  loader accepts a word this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write (load), 0 = read (fetch).
- mem_addr  out  AW  byte address.
- mem_wdata  out  DW  write data.
- mem_ack  in  1  one-cycle completion; read data valid the same cycle.
- mem_rdata  in  DW  read data.
- instr  out  DW  fetched instruction.
- instr_valid  out  1  instr valid toward decode.
- instr_ready  in  1  decode accepts instr.
- br_taken  in  1  taken branch/jump, sampled on the issue handshake.
- br_offset  in  AW  signed PC-relative offset.
- halt_req  in  1  software halt, sampled on the issue handshake.
- pc  out  AW  address of the current/next instruction.
- prog_len  out  clog2(DEPTH+1)  instructions loaded.
- halted  out  1  sequencer in HALT.
- fault  out  2  0 none, 1 load overflow, 2 PC out of range, 3 misaligned target.

Behaviour:
- Reset (async, rstz=0):
  - state=IDLE, pc=BASE_ADDR, prog_len=0, fault=0, count=0.
  - All strobes low; instr=0, mem_addr=0, mem_wdata=0.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the cycle mem_ack=1 with mem_req=1.
  - mem_req drops in the next cycle.
  - mem_ack while mem_req=0 is ignored.
  - At most one transaction is outstanding.
- IDLE:
  - pg=1 -> LOAD: count=0, fault=0.
  - Else if prog_len!=0 -> FETCH.
  - Else stay in IDLE.
- LOAD:
  - pg_ready=1 when no write is outstanding, pg=1 and count<DEPTH.
  - On pg_valid&pg_ready: issue a write with mem_addr=BASE_ADDR+count*IB, mem_wdata=pg_data; count++ on mem_ack.
  - When count==DEPTH, pg_ready stays 0 and fault=1 (sticky until the next LOAD entry). Fault 1 does not halt.
  - When pg=0 and no write is outstanding -> IDLE with prog_len=count, pc=BASE_ADDR.
- FETCH:
  - Issue a read at pc.
  - On mem_ack: instr<=mem_rdata, instr_valid<=1 -> ISSUE.
- ISSUE:
  - instr and instr_valid are held until instr_ready.
  - On the handshake:
    - npc = br_taken ? pc+sext(br_offset) : pc+IB, mod 2^AW.
    - instr_valid clears next cycle.
  - Next state:
    - halt_req=1 -> HALT, fault unchanged, pc unchanged.
    - Else if (npc-BASE_ADDR) mod IB != 0 -> HALT with fault=3.
    - Else if npc<BASE_ADDR or npc>=BASE_ADDR+prog_len*IB -> HALT with fault=2.
    - Otherwise pc<=npc and go to FETCH.
  - A fault leaves pc at the faulting instruction.
- HALT:
  - halted=1.
  - Leaves only on pg=1 (-> LOAD) or reset.
- pg=1 during FETCH or ISSUE:
  - Any outstanding read completes (wait for mem_ack); its data is discarded.
  - instr_valid drops.
  - Enter LOAD with count=0 and prog_len retained until LOAD exits.
- Simultaneous events:
  - pg has priority over the issue handshake: br_taken and halt_req are ignored in the cycle pg=1.
  - A load of 0 words (pg pulse without data) gives prog_len=0, returns to IDLE and fetch does not start.
- Latency:
  - The first fetch request is issued 2 cycles after LOAD exit (IDLE, then FETCH).
  - Minimum throughput is one instruction per 3 cycles with single-cycle mem_ack.

Test Plan:
- Reset mid-load: rstz low during an outstanding write -> pc=16'h8000, prog_len=0, mem_req=0 immediately; no further writes occur.
- Load 4 words A0..A3 with 0-cycle and 3-cycle ack latency -> writes to 8000, 8002, 8004, 8006; prog_len=4; then fetch at 8000 returns A0 with instr_valid=1.
- Sequential run of 4 instructions with instr_ready always 1 -> fetches at 8000, 8002, 8004, 8006.
  - Issue handshake at 8006 gives npc=8008 -> HALT, fault=2, pc=8006.
- Branch at 8002 with br_offset=-2 (16'hFFFE) -> next fetch at 8000. br_offset=3 -> HALT, fault=3.
- Overflow with DEPTH=4: present 5 words -> pg_ready stays low after 4 writes, fault=1, prog_len=4; the run then starts normally.
- pg asserted while instr_valid=1 and instr_ready=0 -> instr_valid falls, LOAD entered; br_taken=1 in that cycle is ignored, shown by pc=8000 after reload.
